scope_cmd_rx: RTL and testbench

SCOPE_CMD_RX -- requirements
Module: scope_cmd_rx

---
 rtl/scope_cmd_rx_pkg.sv | 37 +++
 rtl/scope_cmd_rx_uart_rx_byte.sv | 93 +++++++++
 rtl/scope_cmd_rx.sv | 162 ++++++++++++++++
 tb/tb_scope_cmd_rx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_cmd_rx_pkg.sv
// Shared constants, state types and helpers for the scope command receiver.
// CMD_CHECKSUM_EN adds a trailing XOR checksum state (CHK) to the parser.
package scope_cmd_rx_pkg;

    localparam logic [7:0]  HDR_BYTE       = 8'hA5;
    localparam logic [7:0]  CMD_INTERVAL   = 8'h01;
    localparam logic [7:0]  CMD_TRIG       = 8'h02;
    localparam logic [7:0]  CMD_RUN        = 8'h03;
    localparam logic [31:0] INTERVAL_RESET = 32'd2_700_000;
    localparam logic [31:0] INTERVAL_MIN   = 32'd16;
    localparam logic [7:0]  TRIG_RESET     = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rxState_t;

    typedef enum logic [2:0] {
        HDR,
        CMD,
        D0,
        D1,
        D2,
        D3
`ifdef CMD_CHECKSUM_EN
        , CHK
`endif
    } parseState_t;

    // Intervals shorter than the minimum would starve the ADC sender.
    function automatic logic [31:0] clampInterval(input logic [31:0] value);
        return (value < INTERVAL_MIN) ? INTERVAL_MIN : value;
    endfunction

endpackage

// File: rtl/scope_cmd_rx_uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser, mid-bit sampling, stop-bit check.
module uart_rx_byte
    import scope_cmd_rx_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       stopErr
);

    localparam int unsigned CNT_W    = $clog2(DELAY_FRAMES);
    localparam int unsigned HALF_CNT = DELAY_FRAMES / 2;

    logic [1:0]       rxSync;
    logic             rxPrev;
    logic             rxLine;
    rxState_t         state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;

    assign rxLine = rxSync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxSync   <= 2'b11;
            rxPrev   <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            rxByte   <= '0;
            rxValid  <= 1'b0;
            stopErr  <= 1'b0;
        end else begin
            rxSync  <= {rxSync[0], uart_rx};
            rxPrev  <= rxLine;
            rxValid <= 1'b0;
            stopErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxPrev && !rxLine) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                // Re-check mid start bit so short glitches are dropped silently.
                START: begin
                    if (cnt == CNT_W'(HALF_CNT - 1)) begin
                        cnt    <= '0;
                        bitIdx <= '0;
                        state  <= rxLine ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_W'(DELAY_FRAMES - 1)) begin
                        cnt      <= '0;
                        shiftReg <= {rxLine, shiftReg[7:1]};
                        if (bitIdx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_W'(DELAY_FRAMES - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rxLine) begin
                            rxByte  <= shiftReg;
                            rxValid <= 1'b1;
                        end else begin
                            stopErr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/scope_cmd_rx.sv
// Scope command receiver: UART bytes framed as A5 CMD D0..D3 set interval/trigger/run.
// Define CMD_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module scope_cmd_rx
    import scope_cmd_rx_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES = 234,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic [31:0] interval,
    output logic [7:0]  trig_level,
    output logic        run,
    output logic        cmd_valid,
    output logic        frame_err
);

    localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BITS * DELAY_FRAMES;
    localparam int unsigned TO_W           = $clog2(TIMEOUT_CYCLES);
`ifdef CMD_CHECKSUM_EN
    localparam int unsigned PL_W = 32;
`else
    localparam int unsigned PL_W = 24;
`endif

    logic              stopErr;
    parseState_t       pState;
    logic [7:0]        cmdReg;
    logic [PL_W-1:0]   payload;
    logic [TO_W-1:0]   idleCnt;
    logic              frameDone_c;
    logic              chkOk_c;
    logic [31:0]       finalPayload_c;

    uart_rx_byte #(
        .DELAY_FRAMES(DELAY_FRAMES)
    ) uRx (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .rxByte  (rx_byte),
        .rxValid (rx_valid),
        .stopErr (stopErr)
    );

`ifdef CMD_CHECKSUM_EN
    logic [7:0] chkAcc;

    // Running XOR restarts on the command byte so header bytes never contribute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chkAcc <= '0;
        end else if (rx_valid) begin
            chkAcc <= (pState == CMD) ? rx_byte : (chkAcc ^ rx_byte);
        end
    end
`endif

    // Frame completion and the payload that completes it.
    always_comb begin
`ifdef CMD_CHECKSUM_EN
        frameDone_c    = rx_valid && (pState == CHK);
        chkOk_c        = (rx_byte == chkAcc);
        finalPayload_c = payload;
`else
        frameDone_c    = rx_valid && (pState == D3);
        chkOk_c        = 1'b1;
        finalPayload_c = {payload, rx_byte};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pState     <= HDR;
            cmdReg     <= '0;
            payload    <= '0;
            idleCnt    <= '0;
            interval   <= INTERVAL_RESET;
            trig_level <= TRIG_RESET;
            run        <= 1'b0;
            cmd_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;

            if (pState == HDR || rx_valid) begin
                idleCnt <= '0;
            end else begin
                idleCnt <= idleCnt + TO_W'(1);
            end

            if (stopErr) begin
                pState    <= HDR;
                frame_err <= 1'b1;
            end else if (rx_valid) begin
                // A5 seen past HDR is ordinary data; only HDR looks for the header.
                case (pState)
                    HDR: begin
                        if (rx_byte == HDR_BYTE) begin
                            pState <= CMD;
                        end
                    end
                    CMD: begin
                        cmdReg <= rx_byte;
                        pState <= D0;
                    end
                    D0: begin
                        payload <= {payload[PL_W-9:0], rx_byte};
                        pState  <= D1;
                    end
                    D1: begin
                        payload <= {payload[PL_W-9:0], rx_byte};
                        pState  <= D2;
                    end
                    D2: begin
                        payload <= {payload[PL_W-9:0], rx_byte};
                        pState  <= D3;
                    end
                    D3: begin
                        payload <= {payload[PL_W-9:0], rx_byte};
`ifdef CMD_CHECKSUM_EN
                        pState  <= CHK;
`else
                        pState  <= HDR;
`endif
                    end
                    default: pState <= HDR;
                endcase

                if (frameDone_c) begin
                    if (!chkOk_c) begin
                        frame_err <= 1'b1;
                    end else begin
                        case (cmdReg)
                            CMD_INTERVAL: begin
                                interval  <= clampInterval(finalPayload_c);
                                cmd_valid <= 1'b1;
                            end
                            CMD_TRIG: begin
                                trig_level <= finalPayload_c[7:0];
                                cmd_valid  <= 1'b1;
                            end
                            CMD_RUN: begin
                                run       <= finalPayload_c[0];
                                cmd_valid <= 1'b1;
                            end
                            default: frame_err <= 1'b1;
                        endcase
                    end
                end
            end else if (pState != HDR && idleCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                pState    <= HDR;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scope_cmd_rx.sv
// Self-checking bench for scope_cmd_rx with a frame-level reference model.
// Honours CMD_CHECKSUM_EN the same way as the design.
module tb_scope_cmd_rx;

    localparam int unsigned D       = 52;
    localparam int unsigned TO_BITS = 20;
    localparam int          TO_CYC  = TO_BITS * D;
    localparam int          LAT_EXP = (19 * D) / 2 + 2;
`ifdef CMD_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        uartRx;
    logic [7:0]  rxByte;
    logic        rxValid;
    logic [31:0] interval;
    logic [7:0]  trigLevel;
    logic        run;
    logic        cmdValid;
    logic        frameErr;

    scope_cmd_rx #(
        .DELAY_FRAMES (D),
        .TIMEOUT_BITS (TO_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uartRx),
        .rx_byte    (rxByte),
        .rx_valid   (rxValid),
        .interval   (interval),
        .trig_level (trigLevel),
        .run        (run),
        .cmd_valid  (cmdValid),
        .frame_err  (frameErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nTests = 0;
    int          nFails = 0;
    int          cyc = 0;
    int          rxCnt = 0;
    int          cmdCnt = 0;
    int          errCnt = 0;
    int          lastRxCyc = 0;
    int          txStartCyc = 0;
    bit          cmpEn = 1'b0;
    bit          prevRxValid = 1'b0;
    logic [7:0]  rxQ[$];
    logic [7:0]  frm[$];
    logic [31:0] mInterval;
    logic [7:0]  mTrig;
    logic        mRun;
    int          expCmd;
    int          expErr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            if (nFails <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle-by-cycle comparison of DUT outputs against the model and byte scoreboard.
    always @(negedge clk) begin
        logic [7:0] want;
        if (cmpEn) begin
            check("interval", interval, mInterval);
            check("trig_level", 32'(trigLevel), 32'(mTrig));
            check("run", 32'(run), 32'(mRun));
        end
        if (rxValid) begin
            rxCnt++;
            lastRxCyc = cyc;
            if (rxQ.size() == 0) begin
                nTests++;
                nFails++;
                $display("FAIL rx_unexpected: got 0x%0h expected no byte", rxByte);
            end else begin
                want = rxQ.pop_front();
                check("rx_byte", 32'(rxByte), 32'(want));
            end
        end
        if (cmdValid) begin
            cmdCnt++;
            check("cmd_valid_follows_rx_valid", 32'(prevRxValid), 32'd1);
        end
        if (frameErr) errCnt++;
        prevRxValid = rxValid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic waitCyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        if (stopBit) rxQ.push_back(b);
        txStartCyc = cyc;
        uartRx = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uartRx = b[i];
            repeat (D) @(negedge clk);
        end
        uartRx = stopBit;
        repeat (D) @(negedge clk);
        uartRx = 1'b1;
        repeat (D) @(negedge clk);
    endtask

    function automatic logic [7:0] chkOf(input logic [7:0] cmd, input logic [31:0] pl);
        return cmd ^ pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0];
    endfunction

    task automatic buildFrame(input logic [7:0] cmd, input logic [31:0] pl, input logic [7:0] chk);
        frm = {};
        frm.push_back(8'hA5);
        frm.push_back(cmd);
        for (int i = 3; i >= 0; i--) frm.push_back(pl[8*i +: 8]);
        if (CHK_EN) frm.push_back(chk);
    endtask

    // Frame-level decode: what a complete frame must do to the registers.
    task automatic modelFrame();
        logic [7:0]  cmd;
        logic [31:0] pl;
        cmd = frm[1];
        pl = {frm[2], frm[3], frm[4], frm[5]};
        expCmd = 0;
        expErr = 0;
        if (CHK_EN && frm[6] != chkOf(cmd, pl)) begin
            expErr = 1;
        end else begin
            case (cmd)
                8'h01: begin mInterval = (pl < 32'd16) ? 32'd16 : pl; expCmd = 1; end
                8'h02: begin mTrig = pl[7:0]; expCmd = 1; end
                8'h03: begin mRun = pl[0]; expCmd = 1; end
                default: expErr = 1;
            endcase
        end
    endtask

    task automatic sendFrame(input string name);
        int c0;
        int e0;
        c0 = cmdCnt;
        e0 = errCnt;
        for (int i = 0; i < frm.size() - 1; i++) sendByte(frm[i], 1'b1);
        cmpEn = 1'b0;
        sendByte(frm[frm.size() - 1], 1'b1);
        modelFrame();
        waitCyc(4);
        cmpEn = 1'b1;
        check({name, "_cmd_valid_pulses"}, 32'(cmdCnt - c0), 32'(expCmd));
        check({name, "_frame_err_pulses"}, 32'(errCnt - e0), 32'(expErr));
    endtask

    task automatic checkResetValues(input string name);
        check({name, "_rx_byte"}, 32'(rxByte), 32'h0);
        check({name, "_rx_valid"}, 32'(rxValid), 32'h0);
        check({name, "_cmd_valid"}, 32'(cmdValid), 32'h0);
        check({name, "_frame_err"}, 32'(frameErr), 32'h0);
        check({name, "_run"}, 32'(run), 32'h0);
        check({name, "_trig_level"}, 32'(trigLevel), 32'h80);
        check({name, "_interval"}, interval, 32'd2700000);
    endtask

    initial begin
        int r0;
        int e0;
        int lat;
        bit got;

        rst_n = 1'b0;
        uartRx = 1'b1;
        mInterval = 32'd2700000;
        mTrig = 8'h80;
        mRun = 1'b0;
        waitCyc(3);
        checkResetValues("por");
        rst_n = 1'b1;
        waitCyc(4);
        cmpEn = 1'b1;

        // Single byte: value, one pulse, no error, latency.
        r0 = rxCnt;
        e0 = errCnt;
        sendByte(8'h3C, 1'b1);
        waitCyc(2);
        check("byte_rx_pulses", 32'(rxCnt - r0), 32'd1);
        check("byte_frame_err", 32'(errCnt - e0), 32'd0);
        check("byte_value", 32'(rxByte), 32'h3C);
        lat = lastRxCyc - txStartCyc;
        nTests++;
        if (lat < LAT_EXP - 2 || lat > LAT_EXP + 2) begin
            nFails++;
            $display("FAIL byte_latency: got %0d cycles expected %0d +/-2", lat, LAT_EXP);
        end

        buildFrame(8'h01, 32'd1000, chkOf(8'h01, 32'd1000));
        sendFrame("interval_1000");
        check("interval_1000_value", interval, 32'd1000);

        buildFrame(8'h01, 32'd5, chkOf(8'h01, 32'd5));
        sendFrame("interval_clamp");
        check("interval_clamp_value", interval, 32'd16);

        // Bad stop bit mid-frame: error pulse, no byte, parser back to header hunt.
        sendByte(8'hA5, 1'b1);
        sendByte(8'h01, 1'b1);
        r0 = rxCnt;
        e0 = errCnt;
        sendByte(8'h55, 1'b0);
        waitCyc(2);
        check("stop_err_pulses", 32'(errCnt - e0), 32'd1);
        check("stop_err_no_rx", 32'(rxCnt - r0), 32'd0);

        buildFrame(8'h07, 32'd9, chkOf(8'h07, 32'd9));
        sendFrame("unknown_cmd");

        buildFrame(8'h02, 32'h40, 8'h00);
        sendFrame("trig_badchk");
        check("trig_badchk_value", 32'(trigLevel), CHK_EN ? 32'h80 : 32'h40);

        // Partial frame then silence: timeout error, not before its time.
        sendByte(8'hA5, 1'b1);
        sendByte(8'h03, 1'b1);
        e0 = errCnt;
        waitCyc(TO_CYC - 2 * D);
        check("timeout_not_early", 32'(errCnt - e0), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 3 * D && !got; i++) begin
            @(negedge clk);
            if (errCnt != e0) got = 1'b1;
        end
        check("timeout_err_pulses", 32'(errCnt - e0), 32'd1);

        buildFrame(8'h03, 32'd1, chkOf(8'h03, 32'd1));
        sendFrame("run_on");
        check("run_on_value", 32'(run), 32'd1);

        // Reset while the parser waits for D1, mid-byte.
        sendByte(8'hA5, 1'b1);
        sendByte(8'h01, 1'b1);
        sendByte(8'h00, 1'b1);
        uartRx = 1'b0;
        waitCyc(3 * D);
        cmpEn = 1'b0;
        rst_n = 1'b0;
        uartRx = 1'b1;
        rxQ.delete();
        mInterval = 32'd2700000;
        mTrig = 8'h80;
        mRun = 1'b0;
        #1;
        checkResetValues("async_rst");
        waitCyc(5);
        rst_n = 1'b1;
        waitCyc(2 * D);
        cmpEn = 1'b1;
        buildFrame(8'h01, 32'h7D0, chkOf(8'h01, 32'h7D0));
        sendFrame("after_reset");
        check("after_reset_value", interval, 32'd2000);

        waitCyc(10);
        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
